// File: rtl/lcd_bus_rx.sv
// Responder for the 8-bit HD44780-style LCD write bus: decodes commands and data
// writes into a 2x16 shadow DDRAM with address-counter semantics and a registered read port.
module lcd_bus_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
    input  logic       I_CLK,
    input  logic       I_RSTF,
    input  logic       I_LCD_EN,
    input  logic       I_LCD_RS,
    input  logic       I_LCD_RWF,
    input  logic [7:0] I_LCD_DATA,
    input  logic [4:0] I_RD_ADDR,
    output logic [7:0] O_RD_DATA,
    output logic       O_CMD_WR,
    output logic       O_DATA_WR,
    output logic [7:0] O_LAST_CMD,
    output logic [6:0] O_AC,
    output logic       O_BUSY,
    output logic       O_OVERRUN
);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] rs_sync;
    logic [SYNC_STAGES-1:0] rwf_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   en_d;
    logic                   stb;
    logic                   stb_rs;
    logic                   stb_rwf;
    logic [7:0]             stb_data;

    state_t     state;
    logic [4:0] fill_idx;
    logic       inc;
    logic [7:0] ddram [32];
    logic       wr_hit;
    logic [4:0] wr_idx;

    // RS/RWF/DATA ride the same-depth pipeline as EN; the strobe is registered
    // together with them so the FSM sees a stable, aligned transaction.
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            en_sync  <= '0;
            rs_sync  <= '0;
            rwf_sync <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
            en_d     <= 1'b0;
            stb      <= 1'b0;
            stb_rs   <= 1'b0;
            stb_rwf  <= 1'b0;
            stb_data <= '0;
        end else begin
            en_sync      <= {en_sync[SYNC_STAGES-2:0], I_LCD_EN};
            rs_sync      <= {rs_sync[SYNC_STAGES-2:0], I_LCD_RS};
            rwf_sync     <= {rwf_sync[SYNC_STAGES-2:0], I_LCD_RWF};
            data_sync[0] <= I_LCD_DATA;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            en_d     <= en_sync[SYNC_STAGES-1];
            stb      <= en_d & ~en_sync[SYNC_STAGES-1];
            stb_rs   <= rs_sync[SYNC_STAGES-1];
            stb_rwf  <= rwf_sync[SYNC_STAGES-1];
            stb_data <= data_sync[SYNC_STAGES-1];
        end
    end

    // Two-line wrap: 0x27 <-> 0x40 and 0x67 <-> 0x00.
    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    always_comb begin
        wr_hit = (O_AC[6:4] == 3'b000) || (O_AC[6:4] == 3'b100);
        wr_idx = {O_AC[6], O_AC[3:0]};
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            for (int unsigned i = 0; i < 32; i++) ddram[i] <= BLANK_CHAR;
            state      <= IDLE;
            fill_idx   <= '0;
            inc        <= 1'b1;
            O_AC       <= '0;
            O_LAST_CMD <= '0;
            O_CMD_WR   <= 1'b0;
            O_DATA_WR  <= 1'b0;
            O_BUSY     <= 1'b0;
            O_OVERRUN  <= 1'b0;
        end else begin
            O_CMD_WR  <= 1'b0;
            O_DATA_WR <= 1'b0;
            if (stb && stb_rwf) O_OVERRUN <= 1'b1;
            case (state)
                IDLE: begin
                    if (stb && !stb_rwf) begin
                        if (!stb_rs) begin
                            O_CMD_WR   <= 1'b1;
                            O_LAST_CMD <= stb_data;
                            if (stb_data == 8'h01) begin
                                state    <= CLEAR;
                                O_BUSY   <= 1'b1;
                                fill_idx <= '0;
                                O_AC     <= '0;
                                inc      <= 1'b1;
                            end else if (stb_data[7:1] == 7'b0000_001) begin
                                O_AC <= '0;
                            end else if (stb_data[7:2] == 6'b0000_01) begin
                                inc <= stb_data[1];
                            end else if (stb_data[7]) begin
                                O_AC <= stb_data[6:0];
                            end
                        end else begin
                            O_DATA_WR <= 1'b1;
                            if (wr_hit) ddram[wr_idx] <= stb_data;
                            O_AC <= step_ac(O_AC, inc);
                        end
                    end
                end
                CLEAR: begin
                    ddram[fill_idx] <= BLANK_CHAR;
                    fill_idx        <= fill_idx + 5'd1;
                    if (stb && !stb_rwf) O_OVERRUN <= 1'b1;
                    if (fill_idx == 5'd31) begin
                        state  <= IDLE;
                        O_BUSY <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) O_RD_DATA <= '0;
        else         O_RD_DATA <= ddram[I_RD_ADDR];
    end

endmodule
